// File: rtl/player_controller.sv
// player_controller
// Converts debounced button levels into the sprite position, facing direction
// and player state used by the sprite renderer. Position, direction and state
// change only once per frame, on the cycle after vsync is seen falling. This
// keeps the sprite from tearing mid-frame.
//
// Ports:
//   pixel_clk_in     pixel clock
//   rst_in           synchronous active-high reset
//   vsync_in         VGA vertical sync, active low
//   left_in/right_in/up_in/down_in  direction buttons, level
//   grab_in          grab/drop button, level; a rising level toggles holding
//   chop_in          chop button, level; starts a chop when idle and empty-handed
//   x_out, y_out     sprite top-left position in pixels
//   player_direction 0 left, 1 right, 2 up, 3 down
//   player_state     [1:0] activity (0 idle, 1 walk, 2 chop), [2] holding, [3] zero
//   chop_done_out    one-cycle pulse when a chop runs to completion
module player_controller #(
   parameter int unsigned START_X     = 100,
   parameter int unsigned START_Y     = 100,
   parameter int unsigned SPEED       = 4,
   parameter int unsigned MIN_X       = 32,
   parameter int unsigned MAX_X       = 576,
   parameter int unsigned MIN_Y       = 32,
   parameter int unsigned MAX_Y       = 416,
   parameter int unsigned CHOP_FRAMES = 60
) (
   input  logic        pixel_clk_in,
   input  logic        rst_in,
   input  logic        vsync_in,
   input  logic        left_in,
   input  logic        right_in,
   input  logic        up_in,
   input  logic        down_in,
   input  logic        grab_in,
   input  logic        chop_in,
   output logic [10:0] x_out,
   output logic [9:0]  y_out,
   output logic [1:0]  player_direction,
   output logic [3:0]  player_state,
   output logic        chop_done_out
);

   localparam int unsigned XW = 11;
   localparam int unsigned YW = 10;
   localparam int unsigned PW = 12;   // signed working width for position math
   localparam int unsigned CW = 8;    // chop frame counter width

   localparam logic [1:0] DIR_LEFT  = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_UP    = 2'd2;
   localparam logic [1:0] DIR_DOWN  = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WALK = 2'd1,
      CHOP = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [XW-1:0]  x_q, x_d;
   logic [YW-1:0]  y_q, y_d;
   logic [1:0]     dir_q, dir_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           hold_q, hold_d;
   logic           grab_q, grab_d;
   logic           done_q, done_d;
   logic           vsync_q;
   logic           frame_tick;

   logic           dir_any;
   logic [1:0]     dir_sel;
   logic signed [PW-1:0] x_ext, y_ext;
   logic signed [PW-1:0] x_step, y_step;
   logic signed [PW-1:0] x_mov, y_mov;
   logic signed [PW-1:0] x_clamp, y_clamp;

   // Direction select: up > down > left > right
   always_comb begin
      dir_any = up_in | down_in | left_in | right_in;
      dir_sel = DIR_RIGHT;
      if (up_in)
         dir_sel = DIR_UP;
      else if (down_in)
         dir_sel = DIR_DOWN;
      else if (left_in)
         dir_sel = DIR_LEFT;
   end

   // Candidate position one step in the selected direction, clamped to the play area
   always_comb begin
      x_ext  = signed'(PW'(x_q));
      y_ext  = signed'(PW'(y_q));
      x_step = '0;
      y_step = '0;
      case (dir_sel)
         DIR_LEFT:  x_step = -signed'(PW'(SPEED));
         DIR_RIGHT: x_step =  signed'(PW'(SPEED));
         DIR_UP:    y_step = -signed'(PW'(SPEED));
         default:   y_step =  signed'(PW'(SPEED));
      endcase
      x_mov = x_ext + x_step;
      y_mov = y_ext + y_step;

      x_clamp = x_mov;
      if (x_mov < signed'(PW'(MIN_X)))
         x_clamp = signed'(PW'(MIN_X));
      else if (x_mov > signed'(PW'(MAX_X)))
         x_clamp = signed'(PW'(MAX_X));

      y_clamp = y_mov;
      if (y_mov < signed'(PW'(MIN_Y)))
         y_clamp = signed'(PW'(MIN_Y));
      else if (y_mov > signed'(PW'(MAX_Y)))
         y_clamp = signed'(PW'(MAX_Y));
   end

   // Next-state logic; everything holds unless this is the frame tick
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      grab_d  = grab_q;
      done_d  = 1'b0;

      if (frame_tick) begin
         // Holding toggles on a grab press that was not already held last frame
         grab_d = grab_in;
         hold_d = hold_q ^ (grab_in & ~grab_q);

         // Any direction wins over chop, and also aborts a running chop
         if (dir_any) begin
            state_d = WALK;
            dir_d   = dir_sel;
            x_d     = XW'(x_clamp);
            y_d     = YW'(y_clamp);
            cnt_d   = '0;
         end else begin
            case (state_q)
               IDLE, WALK: begin
                  if (chop_in && !hold_q) begin
                     state_d = CHOP;
                     cnt_d   = CW'(CHOP_FRAMES);
                  end else begin
                     state_d = IDLE;
                  end
               end
               CHOP: begin
                  // Counter at 1 means this tick brings it to zero
                  if (cnt_q <= CW'(1)) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                     done_d  = 1'b1;
                  end else begin
                     cnt_d = cnt_q - CW'(1);
                  end
               end
               default: begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            endcase
         end
      end
   end

   // State register plus vsync edge detection
   always_ff @(posedge pixel_clk_in) begin
      if (rst_in) begin
         state_q    <= IDLE;
         x_q        <= XW'(START_X);
         y_q        <= YW'(START_Y);
         dir_q      <= DIR_DOWN;
         cnt_q      <= '0;
         hold_q     <= 1'b0;
         grab_q     <= 1'b0;
         done_q     <= 1'b0;
         vsync_q    <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         dir_q      <= dir_d;
         cnt_q      <= cnt_d;
         hold_q     <= hold_d;
         grab_q     <= grab_d;
         done_q     <= done_d;
         vsync_q    <= vsync_in;
         // Strobe follows the edge where the sampled vsync goes high to low
         frame_tick <= vsync_q & ~vsync_in;
      end
   end

   assign x_out            = x_q;
   assign y_out            = y_q;
   assign player_direction = dir_q;
   assign player_state     = {1'b0, hold_q, state_q};
   assign chop_done_out    = done_q;

endmodule

// File: doc/player_controller.md
Name: player_controller

Overview:
- Upstream of the player sprite renderer.
- Turns debounced button inputs into the registered sprite position (x, y), facing direction and 4-bit player state that the renderer consumes.
- Updates are applied once per frame, at the start of vertical sync, so the sprite never tears mid-frame.
- Runs in the pixel clock domain alongside the VGA timing generator.

Parameters:
START_X, 100, reset x (top-left, pixels)
START_Y, 100, reset y (top-left, pixels)
SPEED, 4, pixels moved per frame while walking
MIN_X, 32, smallest legal x
MAX_X, 576, largest legal x (play-area right edge minus sprite width 32)
MIN_Y, 32, smallest legal y
MAX_Y, 416, largest legal y
CHOP_FRAMES, 60, frames a chop action takes (1..255)

Ports:
pixel_clk_in  input  1  pixel clock
rst_in  input  1  synchronous active-high reset
vsync_in  input  1  VGA vsync, active low
left_in  input  1  left button, debounced, level
right_in  input  1  right button, level
up_in  input  1  up button, level
down_in  input  1  down button, level
grab_in  input  1  grab/drop button, level
chop_in  input  1  chop button, level
x_out  output  11  sprite x
y_out  output  10  sprite y
player_direction  output  2  0 left, 1 right, 2 up, 3 down
player_state  output  4  [1:0] activity (0 idle, 1 walk, 2 chop), [2] holding, [3] always 0
chop_done_out  output  1  one-cycle pulse when a chop completes

Behaviour:
- One clock (pixel_clk_in). Reset is synchronous and active-high (rst_in).
- All outputs are registered.
- Reset values:
  - x_out=START_X, y_out=START_Y
  - player_direction=3 (down)
  - player_state=0
  - chop_done_out=0
  - chop counter=0
  - vsync history=1
  - grab history=0
- Reset asserted mid-chop or mid-move returns every output to its reset value on the next edge, with no chop_done pulse.
- frame_tick: a one-cycle internal strobe, asserted in the cycle after vsync_in is registered going 1->0. Exactly one per frame.
- All state, position and direction changes happen only on the edge where frame_tick=1. Outputs are stable otherwise.
- Buttons are sampled at frame_tick.
- Direction select when several are held: priority up > down > left > right.
- FSM states: IDLE, WALK, CHOP.
  - IDLE/WALK, direction held:
    - enter/stay WALK
    - player_direction = selected direction
    - position moves SPEED in that direction
  - IDLE/WALK, no direction held:
    - chop_in=1 and holding=0 -> CHOP, counter=CHOP_FRAMES
    - otherwise -> IDLE
  - Direction beats chop when both are pressed in the same frame.
  - CHOP:
    - position frozen
    - counter decrements each frame_tick
    - when the counter reaches 0 -> IDLE, and chop_done_out=1 for exactly that one cycle
    - any direction held while in CHOP aborts the chop: -> WALK on that frame, moving and turning as in WALK, no chop_done pulse
    - chop_in released has no effect; the chop continues
- Position arithmetic:
  - computed at 12 bits signed, then clamped to [MIN_X,MAX_X] / [MIN_Y,MAX_Y]
  - e.g. x=34, SPEED=4, left -> 32, not 30; pushing further holds 32
  - Hitting a clamp still sets direction and state WALK.
- Holding bit (player_state[2]):
  - toggles when grab_in=1 at this frame_tick and was 0 at the previous frame_tick
  - grab history updates every frame_tick
  - toggling is allowed in any state, including CHOP
  - if set during CHOP, the chop continues to completion
- player_state[1:0] mirrors the FSM state (IDLE=0, WALK=1, CHOP=2). Encoding 3 never occurs.

Test Plan:
- Reset then 3 frames no input:
  - x_out=100, y_out=100, player_direction=3, player_state=0
  - no output change between frame ticks
- Hold right 5 frames:
  - x_out=120, player_direction=1, player_state[1:0]=1
  - each change lands exactly one cycle after the vsync falling edge
  - release -> state 0 next frame
- From x=40, hold left 4 frames:
  - x sequence 36, 32, 32, 32
  - direction 0, state WALK throughout
- Hold up+left together:
  - y decreases by 4 per frame, x unchanged, direction 2
- Chop, idle not holding, chop_in 1 frame then released:
  - state=2 for 60 frames
  - chop_done_out high exactly 1 cycle, at the 60th subsequent frame_tick; state 0 after
  - second run: down pressed at frame 30 -> state 1, y+4, no chop_done pulse
- Grab, with a reset check:
  - pulse grab -> player_state=4
  - chop_in now ignored (state stays 4)
  - grab again -> 0
  - assert rst_in during a chop -> all outputs at reset values next edge, no pulse
